// File: rtl/axis_llr_packer.sv
// axis_llr_packer: packs a stream of signed 8-bit LLR samples into
// DATA_WIDTH-bit AXI-Stream beats, little-endian by lane. A beat closes early
// at a codeword boundary, and its unused lanes are zeroed and masked by tkeep.
module axis_llr_packer #(
  parameter int  DATA_WIDTH = 64,
  localparam int BYTES      = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [BYTES-1:0]      m_tkeep,
  output logic                  m_tlast,
  output logic [15:0]           frame_count
);

  localparam int FW = $clog2(BYTES);

  logic [FW-1:0]         fill_q,        fill_d;
  logic [DATA_WIDTH-1:0] acc_q,         acc_d;
  logic [DATA_WIDTH-1:0] m_tdata_q,     m_tdata_d;
  logic [BYTES-1:0]      m_tkeep_q,     m_tkeep_d;
  logic                  m_tlast_q,     m_tlast_d;
  logic                  m_tvalid_q,    m_tvalid_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  completing;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [BYTES-1:0]      keep_new;

  // Input may advance whenever the output register is empty or draining;
  // held low throughout reset.
  assign s_tready = aresetn & (~m_tvalid_q | m_tready);

  // Datapath: merge the incoming sample into its lane and build the beat.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch can be inferred.
    in_xfer    = s_tvalid & s_tready;
    out_xfer   = m_tvalid_q & m_tready;
    completing = (fill_q == FW'(BYTES - 1)) | s_tlast;
    merged     = acc_q;
    keep_new   = '0;
    lane_mask  = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (FW'(i) == fill_q) merged[8*i +: 8] = s_tdata;
      keep_new[i]         = (FW'(i) <= fill_q);
      lane_mask[8*i +: 8] = {8{keep_new[i]}};
    end
  end

  // Next-state: fill/accumulator advance, output beat load and drain.
  always_comb begin
    fill_d        = fill_q;
    acc_d         = acc_q;
    m_tdata_d     = m_tdata_q;
    m_tkeep_d     = m_tkeep_q;
    m_tlast_d     = m_tlast_q;
    m_tvalid_d    = m_tvalid_q;
    frame_count_d = frame_count_q;

    if (out_xfer) begin
      m_tvalid_d = 1'b0;
      if (m_tlast_q) frame_count_d = frame_count_q + 16'd1;
    end

    if (in_xfer) begin
      if (completing) begin
        // Lanes above fill are already zero in acc_q; masking keeps that
        // guarantee local to this load.
        m_tdata_d  = merged & lane_mask;
        m_tkeep_d  = keep_new;
        m_tlast_d  = s_tlast;
        m_tvalid_d = 1'b1;
        fill_d     = '0;
        acc_d      = '0;
      end else begin
        fill_d = fill_q + FW'(1);
        acc_d  = merged;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // values, independent of statement order.
    if (!aresetn) begin
      fill_q        <= '0;
      acc_q         <= '0;
      m_tdata_q     <= '0;
      m_tkeep_q     <= '0;
      m_tlast_q     <= 1'b0;
      m_tvalid_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      fill_q        <= fill_d;
      acc_q         <= acc_d;
      m_tdata_q     <= m_tdata_d;
      m_tkeep_q     <= m_tkeep_d;
      m_tlast_q     <= m_tlast_d;
      m_tvalid_q    <= m_tvalid_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = m_tdata_q;
  assign m_tkeep     = m_tkeep_q;
  assign m_tlast     = m_tlast_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_axis_llr_packer.sv
// Testbench for axis_llr_packer (DATA_WIDTH=32). A queue-based model chunks
// accepted samples into expected beats; a negedge monitor scores every cycle,
// and directed steps check the literal beats of each scenario.
module tb_axis_llr_packer;

  localparam int DW    = 32;
  localparam int BYTES = DW / 8;

  typedef struct {
    logic [DW-1:0]    data;
    logic [BYTES-1:0] keep;
    logic             last;
  } beat_t;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic             s_tvalid;
  logic             s_tready;
  logic [7:0]       s_tdata;
  logic             s_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [DW-1:0]    m_tdata;
  logic [BYTES-1:0] m_tkeep;
  logic             m_tlast;
  logic [15:0]      frame_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  beat_t      exp_q[$];
  beat_t      got[$];
  logic [7:0] cur[$];
  int         in_stamp[$];
  logic [15:0] model_fc = 16'd0;

  axis_llr_packer #(.DATA_WIDTH(DW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tdata     (s_tdata),
    .s_tlast     (s_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata),
    .m_tkeep     (m_tkeep),
    .m_tlast     (m_tlast),
    .frame_count (frame_count)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge aclk) begin
    beat_t b;
    check("s_tready", 64'(s_tready), 64'(aresetn & (~m_tvalid | m_tready)));
    check("m_tvalid", 64'(m_tvalid), 64'(exp_q.size() != 0));
    if (m_tvalid && exp_q.size() != 0) begin
      check("m_tdata", 64'(m_tdata), 64'(exp_q[0].data));
      check("m_tkeep", 64'(m_tkeep), 64'(exp_q[0].keep));
      check("m_tlast", 64'(m_tlast), 64'(exp_q[0].last));
    end
    check("frame_count", 64'(frame_count), 64'(model_fc));
    if (!aresetn) begin
      exp_q.delete();
      cur.delete();
      model_fc = 16'd0;
    end else begin
      if (m_tvalid && m_tready && exp_q.size() != 0) begin
        b.data = m_tdata;
        b.keep = m_tkeep;
        b.last = m_tlast;
        got.push_back(b);
        if (exp_q[0].last) model_fc = model_fc + 16'd1;
        void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        in_stamp.push_back(cyc);
        cur.push_back(s_tdata);
        if (cur.size() == BYTES || s_tlast) begin
          b.data = '0;
          for (int i = 0; i < cur.size(); i++) b.data |= DW'(cur[i]) << (8 * i);
          b.keep = BYTES'((1 << cur.size()) - 1);
          b.last = s_tlast;
          exp_q.push_back(b);
          cur.delete();
        end
      end
    end
  end

  // All stimulus steps start at posedge+1.
  task automatic send(input logic [7:0] d, input logic last);
    bit took;
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    n        = 0;
    do begin
      @(negedge aclk);
      took = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      n++;
    end while (!took && n < 200);
    if (!took) check("send_timeout", 64'(0), 64'(1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge aclk);
    check("rst_s_tready", 64'(s_tready), 64'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    got.delete();
    in_stamp.delete();
  endtask

  initial begin
    bit took;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    @(posedge aclk);
    #1;
    @(negedge aclk);
    check("reset_m_tvalid", 64'(m_tvalid), 64'(0));
    check("reset_m_tdata", 64'(m_tdata), 64'(0));
    check("reset_m_tkeep", 64'(m_tkeep), 64'(0));
    check("reset_frame_count", 64'(frame_count), 64'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_reset_no_beat", 64'(m_tvalid), 64'(0));
    @(posedge aclk);
    #1;

    // Two full beats from eight consecutive samples.
    do_reset();
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    idle(3);
    check("t1_beats", 64'(got.size()), 64'(2));
    check("t1_b0_data", 64'(got[0].data), 64'h04030201);
    check("t1_b0_keep", 64'(got[0].keep), 64'hF);
    check("t1_b0_last", 64'(got[0].last), 64'(0));
    check("t1_b1_data", 64'(got[1].data), 64'h08070605);
    check("t1_b1_keep", 64'(got[1].keep), 64'hF);
    check("t1_b1_last", 64'(got[1].last), 64'(1));
    check("t1_no_bubbles", 64'(in_stamp[7] - in_stamp[0]), 64'(7));
    check("t1_frame_count", 64'(frame_count), 64'(1));

    // Short codeword of three samples.
    do_reset();
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b1);
    idle(3);
    check("t2_beats", 64'(got.size()), 64'(1));
    check("t2_data", 64'(got[0].data), 64'h00A3A2A1);
    check("t2_keep", 64'(got[0].keep), 64'h7);
    check("t2_last", 64'(got[0].last), 64'(1));

    // Single-sample codeword.
    got.delete();
    send(8'h7F, 1'b1);
    idle(3);
    check("t3_data", 64'(got[0].data), 64'h0000007F);
    check("t3_keep", 64'(got[0].keep), 64'h1);
    check("t3_last", 64'(got[0].last), 64'(1));
    check("t3_frame_count", 64'(frame_count), 64'(2));

    // Backpressure: beat held for five cycles, pending sample not lost.
    do_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i), 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 8'h15;
    s_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("t4_stall_s_tready", 64'(s_tready), 64'(0));
      check("t4_hold_valid", 64'(m_tvalid), 64'(1));
      check("t4_hold_data", 64'(m_tdata), 64'h14131211);
      check("t4_hold_keep", 64'(m_tkeep), 64'hF);
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send(8'h15, 1'b0);
    send(8'h16, 1'b0);
    send(8'h17, 1'b0);
    send(8'h18, 1'b1);
    idle(3);
    check("t4_beats", 64'(got.size()), 64'(2));
    check("t4_b0_data", 64'(got[0].data), 64'h14131211);
    check("t4_b1_data", 64'(got[1].data), 64'h18171615);
    check("t4_b1_last", 64'(got[1].last), 64'(1));

    // Reset mid-codeword discards the partial beat.
    do_reset();
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    do_reset();
    @(negedge aclk);
    check("t5_no_beat", 64'(m_tvalid), 64'(0));
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i), 1'b0);
    idle(3);
    check("t5_beats", 64'(got.size()), 64'(1));
    check("t5_data", 64'(got[0].data), 64'h34333231);
    check("t5_keep", 64'(got[0].keep), 64'hF);
    check("t5_last", 64'(got[0].last), 64'(0));
    check("t5_fc_before", 64'(frame_count), 64'(0));
    send(8'h35, 1'b1);
    idle(3);
    check("t5_tail_data", 64'(got[1].data), 64'h00000035);
    check("t5_tail_keep", 64'(got[1].keep), 64'h1);
    check("t5_fc_after", 64'(frame_count), 64'(1));

    // Randomized traffic with random backpressure against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      @(negedge aclk);
      took = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      if (took || !s_tvalid) begin
        s_tvalid = ($urandom % 4) != 0;
        s_tdata  = 8'($urandom);
        s_tlast  = ($urandom % 5) == 0;
      end
      m_tready = ($urandom % 3) != 0;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    idle(4);
    check("rand_drained", 64'(exp_q.size()), 64'(0));
    check("rand_fc", 64'(frame_count), 64'(model_fc));

    // 65537 single-sample codewords: frame_count wraps to 1.
    do_reset();
    s_tvalid = 1'b1;
    s_tlast  = 1'b1;
    s_tdata  = 8'($urandom);
    repeat (65537) @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    idle(3);
    check("wrap_accepted", 64'(in_stamp.size()), 64'(65537));
    check("wrap_frame_count", 64'(frame_count), 64'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_llr_packer.md
AXIS_LLR_PACKER -- requirements
Module: axis_llr_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, output beat width in bits; legal values are multiples of 8 and at least 16.
REQ-002 SHALL have derived constant BYTES = DATA_WIDTH/8, the number of 8-bit LLR samples per output beat.
REQ-003 SHALL have a single clock and synchronous active-low reset: aclk (input, 1, clock) and aresetn (input, 1, synchronous active-low reset).
REQ-004 SHALL have port s_tvalid (input, 1): input sample valid.
REQ-005 SHALL have port s_tready (output, 1): input sample accepted when high together with s_tvalid.
REQ-006 SHALL have port s_tdata (input, 8): one signed LLR sample.
REQ-007 SHALL have port s_tlast (input, 1): last sample of a codeword.
REQ-008 SHALL have port m_tvalid (output, 1): output beat valid.
REQ-009 SHALL have port m_tready (input, 1): downstream ready.
REQ-010 SHALL have port m_tdata (output, DATA_WIDTH): packed LLR beat.
REQ-011 SHALL have port m_tkeep (output, BYTES): byte-valid mask for m_tdata.
REQ-012 SHALL have port m_tlast (output, 1): beat carries the last sample of a codeword.
REQ-013 SHALL have port frame_count (output, 16): count of codewords fully emitted.

Function
REQ-014 SHALL define an input transfer as s_tvalid & s_tready and an output transfer as m_tvalid & m_tready.
REQ-015 SHALL drive s_tready = !m_tvalid | m_tready combinationally, so input stalls only while a beat is held and not drained.
REQ-016 SHALL keep a fill counter fill (0..BYTES-1) and an accumulation register; each accepted sample is written to accumulation byte lane fill, bits [8*fill+7:8*fill], little-endian.
REQ-017 SHALL treat a sample as completing when fill = BYTES-1 or s_tlast = 1.
REQ-018 On a non-completing accepted sample, SHALL increment fill and leave the output registers unchanged.
REQ-019 On a completing accepted sample, SHALL in the same edge load m_tdata with the accumulated lanes plus the new sample, load m_tkeep with ones in bits [fill:0] and zeros above, load m_tlast = s_tlast, set m_tvalid = 1, and clear fill and the accumulation register to 0.
REQ-020 SHALL zero all m_tdata byte lanes whose m_tkeep bit is 0.
REQ-021 SHALL present the beat at m_tvalid one cycle after the completing sample's transfer (latency 1).
REQ-022 SHALL hold m_tdata, m_tkeep and m_tlast stable while m_tvalid = 1 and m_tready = 0.
REQ-023 SHALL clear m_tvalid after an output transfer unless a completing sample is accepted in the same cycle, in which case the new beat is loaded back-to-back with m_tvalid staying 1.
REQ-024 SHALL sustain one sample per cycle whenever m_tready = 1 continuously, with no bubbles at beat boundaries.
REQ-025 SHALL emit a full beat with m_tlast = 1 and m_tkeep all ones when s_tlast coincides with fill = BYTES-1.
REQ-026 SHALL start a single-sample codeword (s_tlast on the first sample) as one beat with m_tkeep = 1.
REQ-027 SHALL increment frame_count by 1 on each output transfer with m_tlast = 1, wrapping 0xFFFF -> 0x0000.
REQ-028 SHALL never merge samples from different codewords into one beat.

Reset
REQ-029 While aresetn = 0 at a rising aclk edge, SHALL clear m_tvalid, m_tdata, m_tkeep, m_tlast, fill, the accumulation register and frame_count to 0.
REQ-030 During reset, SHALL drive s_tready as 0.
REQ-031 SHALL discard any partial beat on reset mid-codeword; the first sample after reset deassertion goes to lane 0.
REQ-032 SHALL produce no output transfer in the first cycle after reset deassertion.

Verification (DATA_WIDTH=32, BYTES=4)
REQ-033 SHALL cover: samples 0x01..0x08, s_tlast on 0x08, m_tready=1 -> beats 0x04030201/keep 0xF/last 0, then 0x08070605/keep 0xF/last 1, back-to-back; frame_count=1.
REQ-034 SHALL cover: samples 0xA1,0xA2,0xA3 with s_tlast on 0xA3 -> one beat 0x00A3A2A1, keep 0x7, last 1.
REQ-035 SHALL cover: single sample 0x7F with s_tlast -> beat 0x0000007F, keep 0x1, last 1.
REQ-036 SHALL cover: m_tready held 0 for 5 cycles while a beat is pending -> s_tready=0, beat held stable, no sample lost; the stream resumes correctly once m_tready=1.
REQ-037 SHALL cover: aresetn pulsed low after 2 of 4 samples -> no beat emitted; the next 4 samples form a beat starting at lane 0; frame_count=0 until the next m_tlast transfer.
REQ-038 SHALL cover: 65537 single-sample codewords -> frame_count wraps to 0x0001.
